// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU, response and stats bundle for alu_arbiter.
// slave = arbiter side, master = client/ALU/environment side.
interface alu_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_SIZE = 32,
  parameter int CMD_W    = 8,
  parameter int ID_W     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*CMD_W-1:0]    req_cmd;
  logic [NUM_REQ*NUM_SIZE-1:0] req_in1;
  logic [NUM_REQ*NUM_SIZE-1:0] req_in2;
  logic [NUM_SIZE-1:0]         alu_in1;
  logic [NUM_SIZE-1:0]         alu_in2;
  logic [CMD_W-1:0]            alu_cmd;
  logic [NUM_SIZE-1:0]         alu_out;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [ID_W-1:0]             rsp_id;
  logic [NUM_SIZE-1:0]         rsp_data;
  logic                        busy;
  logic [31:0]                 op_count;
  logic [31:0]                 stall_count;

  modport slave (
    input  req_valid, req_cmd, req_in1, req_in2,
    input  alu_out, rsp_ready,
    output req_ready, alu_in1, alu_in2, alu_cmd,
    output rsp_valid, rsp_id, rsp_data, busy,
    output op_count, stall_count
  );

  modport master (
    output req_valid, req_cmd, req_in1, req_in2,
    output alu_out, rsp_ready,
    input  req_ready, alu_in1, alu_in2, alu_cmd,
    input  rsp_valid, rsp_id, rsp_data, busy,
    input  op_count, stall_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one fixed-latency ALU among NUM_REQ
// requesters, one op in flight, result returned tagged with requester id.
// Ports: clk, reset (async, active-high), bus (alu_arbiter_if.slave):
//   req_valid/req_ready/req_cmd/req_in1/req_in2 : request side
//   alu_in1/alu_in2/alu_cmd/alu_out             : ALU side
//   rsp_valid/rsp_ready/rsp_id/rsp_data         : response side
//   busy, op_count, stall_count                 : status
// Optional: define ALU_STATS_EN for saturating op/stall counters.
module alu_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_SIZE = 32,
  parameter int CMD_W    = 8,
  parameter int ALU_LAT  = 1,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  localparam int CW = $clog2(ALU_LAT + 1);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_SIZE-1:0] in1_q, in1_d;
  logic [NUM_SIZE-1:0] in2_q, in2_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [NUM_SIZE-1:0] data_q, data_d;

  logic            found;
  logic [ID_W-1:0] win;
  int              idx;

  // search upward from last_grant+1, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      id_q    <= '0;
      cnt_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          last_d  = win;
          id_d    = win;
          in1_d   = bus.req_in1[int'(win)*NUM_SIZE +: NUM_SIZE];
          in2_d   = bus.req_in2[int'(win)*NUM_SIZE +: NUM_SIZE];
          cmd_d   = bus.req_cmd[int'(win)*CMD_W +: CMD_W];
        end
      end
      ISSUE: begin
        cnt_d   = CW'(ALU_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          data_d  = bus.alu_out;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is gated by reset so every output reads 0 while reset is held
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && found && !reset)
      bus.req_ready[win] = 1'b1;
    bus.busy      = (state_q != IDLE);
    bus.rsp_valid = (state_q == RESP);
  end

  assign bus.alu_in1  = in1_q;
  assign bus.alu_in2  = in2_q;
  assign bus.alu_cmd  = cmd_q;
  assign bus.rsp_id   = id_q;
  assign bus.rsp_data = data_q;

`ifdef ALU_STATS_EN
  logic [31:0] ops_q, ops_d;
  logic [31:0] stl_q, stl_d;

  always_comb begin
    ops_d = ops_q;
    stl_d = stl_q;
    if (state_q == RESP) begin
      if (bus.rsp_ready && ops_q != '1)
        ops_d = ops_q + 32'd1;
      if (!bus.rsp_ready && stl_q != '1)
        stl_d = stl_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops_q <= '0;
      stl_q <= '0;
    end else begin
      ops_q <= ops_d;
      stl_q <= stl_d;
    end
  end

  assign bus.op_count    = ops_q;
  assign bus.stall_count = stl_q;
`else
  assign bus.op_count    = '0;
  assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed + random stimulus for alu_arbiter against a
// transaction-level model (round-robin grant, ALU result, counters).
module tb_alu_arbiter;
  localparam int NR = 4;
  localparam int NS = 32;
  localparam int CW = 8;
  localparam int IW = $clog2(NR);
  parameter int ALU_LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(
    .NUM_REQ(NR), .NUM_SIZE(NS), .CMD_W(CW), .ID_W(IW)
  ) bus ();

  alu_arbiter #(
    .NUM_REQ(NR), .NUM_SIZE(NS), .CMD_W(CW),
    .ALU_LAT(ALU_LAT), .ID_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [NS-1:0] a_op [NR];
  logic [NS-1:0] b_op [NR];
  logic [CW-1:0] c_op [NR];
  int            m_last;
  logic [31:0]   m_ops;
  logic [31:0]   m_stalls;
  logic [NS-1:0] pipe [ALU_LAT];

  function automatic logic [NS-1:0] alu_ref(
    input logic [CW-1:0] c, input logic [NS-1:0] a, input logic [NS-1:0] b
  );
    case (c)
      8'd0:    return a + b;
      8'd1:    return a - b;
      8'd2:    return a & b;
      8'd3:    return a ^ b;
      default: return a | b;
    endcase
  endfunction

  // stand-in ALU: computes every cycle, result appears ALU_LAT edges later
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= alu_ref(bus.alu_cmd, bus.alu_in1, bus.alu_in2);
    for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.alu_out = pipe[ALU_LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_in1[i*NS +: NS] = a_op[i];
      bus.req_in2[i*NS +: NS] = b_op[i];
      bus.req_cmd[i*CW +: CW] = c_op[i];
    end
  endtask

  function automatic int winner(input logic [NR-1:0] m);
    int j;
    for (int k = 1; k <= NR; k++) begin
      j = (m_last + k) % NR;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk_stats();
`ifdef ALU_STATS_EN
    chk("op_count", bus.op_count, m_ops);
    chk("stall_count", bus.stall_count, m_stalls);
`else
    chk("op_count_off", bus.op_count, 0);
    chk("stall_count_off", bus.stall_count, 0);
`endif
  endtask

  // one full transaction starting in an IDLE cycle
  task automatic do_txn(input logic [NR-1:0] mask, input int stall,
                        output int gid, output int acc,
                        output logic [NS-1:0] got);
    int w;
    logic [NS-1:0] ea, eb, er;
    logic [CW-1:0] ec;
    drive();
    bus.req_valid = mask;
    w = winner(mask);
    ea = a_op[w];
    eb = b_op[w];
    ec = c_op[w];
    er = alu_ref(ec, ea, eb);
    @(negedge clk);
    chk("idle_rsp_valid", bus.rsp_valid, 0);
    chk("idle_busy", bus.busy, 0);
    chk("grant", bus.req_ready, 1 << w);
    @(posedge clk);
    #1;
    acc = cyc;
    m_last = w;
    a_op[w] = $urandom;
    b_op[w] = $urandom;
    c_op[w] = CW'($urandom_range(0, 4));
    drive();
    for (int c = 1; c <= 1 + ALU_LAT; c++) begin
      @(negedge clk);
      chk("busy", bus.busy, 1);
      chk("early_rsp", bus.rsp_valid, 0);
      chk("ready_busy", bus.req_ready, 0);
      if (c == 1) begin
        chk("alu_in1", bus.alu_in1, ea);
        chk("alu_in2", bus.alu_in2, eb);
        chk("alu_cmd", bus.alu_cmd, ec);
      end
      @(posedge clk);
      #1;
    end
    for (int s = 0; s < stall; s++) begin
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("stall_valid", bus.rsp_valid, 1);
      chk("stall_id", bus.rsp_id, w);
      chk("stall_data", bus.rsp_data, er);
      chk("stall_ready", bus.req_ready, 0);
      @(posedge clk);
      #1;
      m_stalls++;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_id", bus.rsp_id, w);
    chk("rsp_data", bus.rsp_data, er);
    gid = int'(bus.rsp_id);
    got = bus.rsp_data;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    m_ops++;
    chk("rsp_drop", bus.rsp_valid, 0);
    chk_stats();
  endtask

  initial begin
    int gid, acc, prev;
    logic [NS-1:0] got, lit;
    logic [NR-1:0] mask;
    m_last = NR - 1;
    m_ops = '0;
    m_stalls = '0;
    for (int i = 0; i < NR; i++) begin
      a_op[i] = $urandom;
      b_op[i] = $urandom;
      c_op[i] = CW'($urandom_range(0, 4));
    end
    drive();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_alu_in1", bus.alu_in1, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk_stats();
    @(posedge clk);
    #1;
    reset = 1'b0;

    prev = 0;
    for (int n = 0; n < 5; n++) begin
      do_txn(4'hF, 0, gid, acc, got);
      chk("rr_order", gid, n % NR);
      if (n > 0) chk("spacing", acc - prev, 3 + ALU_LAT);
      prev = acc;
    end

    a_op[0] = NS'(5);
    b_op[0] = NS'(7);
    c_op[0] = 8'd0;
    do_txn(4'b0001, 0, gid, acc, got);
    lit = NS'(12);
    chk("add_5_7", got, lit);

    a_op[0] = NS'(-10);
    b_op[0] = NS'(3);
    c_op[0] = 8'd0;
    do_txn(4'b0001, 0, gid, acc, got);
    lit = 32'hFFFF_FFF9;
    chk("signed_add", got, lit);

    do_txn(4'b0110, 5, gid, acc, got);

    for (int n = 0; n < 12; n++) begin
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      do_txn(mask, $urandom_range(0, 3), gid, acc, got);
    end

    drive();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("pre_rst_grant", bus.req_ready, 1 << winner(4'b0100));
    m_last = winner(4'b0100);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_ready", bus.req_ready, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_rsp_valid", bus.rsp_valid, 0);
    chk("mid_alu_in1", bus.alu_in1, 0);
    chk("mid_alu_cmd", bus.alu_cmd, 0);
    chk("mid_rsp_id", bus.rsp_id, 0);
    chk("mid_rsp_data", bus.rsp_data, 0);
    m_last = NR - 1;
    m_ops = '0;
    m_stalls = '0;
    chk_stats();
    bus.rsp_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_rsp", bus.rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.rsp_ready = 1'b0;
    do_txn(4'b1010, 0, gid, acc, got);
    chk("post_rst_first", gid, 1);
    do_txn(4'b1000, 0, gid, acc, got);
    chk("post_rst_r3", gid, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
